uart_fifo_ctrl: RTL

Control and sequencing block for the 16750 UART receive/transmit FIFOs. Decodes FCR writes into FIFO enable, 16/64-byte mode, trigger level and one-cycle clear pulses. Watches RX FIFO occupancy to produce the received-data-available (RDA) and character-timeout (CTO) interrupt conditions. Sits between the register file and the two slib_fifo instances, and feeds the interrupt priority logic.

---
 rtl/uart_fifo_ctrl.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_fifo_ctrl
//
// Control and sequencing for the 16750-style UART RX/TX FIFOs.
//  - Decodes FCR writes into FIFO enable, 16/64-byte mode, trigger code and
//    one-cycle RX/TX clear pulses.
//  - Watches RX FIFO occupancy and produces the received-data-available (RDA)
//    condition, the effective RX full limit and the character-timeout (CTO)
//    condition.
//
// Ports
//  CLK, RST      : clock (rising edge), asynchronous active-high reset
//  FCR_WE, FCR_D : one-cycle FCR write strobe and data
//                  (bit0 enable, bit1 RX clear, bit2 TX clear, bit5 FIFO64,
//                   bits7:6 trigger code)
//  DLAB          : LCR[7]; FIFO64 can only be changed while it is set
//  FRAME_BITS    : bits per character, sets the timeout threshold
//  BAUDCE        : 16x baud tick
//  RX_USAGE, RX_EMPTY, RX_FULL, RX_PUSH, RX_POP : RX FIFO status / activity
//  FIFOEN, FIFO64              : current FIFO mode
//  RXCLEAR, TXCLEAR            : one-cycle synchronous FIFO clears
//  RX_LIMIT, RDA, CTO          : registered RX status for receiver / IRQ logic
// ---------------------------------------------------------------------------
module uart_fifo_ctrl #(
    parameter int SIZE_E = 6,
    parameter int TO_W   = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FCR_WE,
    input  logic [7:0]        FCR_D,
    input  logic              DLAB,
    input  logic [3:0]        FRAME_BITS,
    input  logic              BAUDCE,
    input  logic [SIZE_E-1:0] RX_USAGE,
    input  logic              RX_EMPTY,
    input  logic              RX_FULL,
    input  logic              RX_PUSH,
    input  logic              RX_POP,
    output logic              FIFOEN,
    output logic              FIFO64,
    output logic              RXCLEAR,
    output logic              TXCLEAR,
    output logic              RX_LIMIT,
    output logic              RDA,
    output logic              CTO
);

    // Compare width wide enough for both the usage value and the largest level.
    localparam int CMP_W = (SIZE_E >= 8) ? SIZE_E + 1 : 8;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_PULSE = 1'b1
    } clr_state_t;

    typedef enum logic [1:0] {
        TO_IDLE    = 2'b00,
        TO_COUNT   = 2'b01,
        TO_EXPIRED = 2'b10
    } to_state_t;

    // Trigger level in bytes for the given mode and FCR[7:6] code.
    function automatic logic [7:0] trig_level(input logic f64, input logic [1:0] code);
        logic [7:0] lvl;
        if (f64) begin
            case (code)
                2'b00:   lvl = 8'd1;
                2'b01:   lvl = 8'd16;
                2'b10:   lvl = 8'd32;
                2'b11:   lvl = 8'd56;
                default: lvl = 8'd1;
            endcase
        end else begin
            case (code)
                2'b00:   lvl = 8'd1;
                2'b01:   lvl = 8'd4;
                2'b10:   lvl = 8'd8;
                2'b11:   lvl = 8'd14;
                default: lvl = 8'd1;
            endcase
        end
        return lvl;
    endfunction

    logic             fifoen_r;
    logic             fifo64_r;
    logic [1:0]       trig_r;
    clr_state_t       clr_state_r;
    logic             rxclear_r;
    logic             txclear_r;
    logic             rda_r;
    logic             rx_limit_r;
    logic             cto_r;
    to_state_t        to_state_r;
    logic [TO_W-1:0]  to_cnt_r;

    logic             en_toggle_s;
    clr_state_t       clr_next_s;
    logic             rxc_next_s;
    logic             txc_next_s;
    logic [CMP_W-1:0] usage_s;
    logic [CMP_W-1:0] level_s;
    logic             rda_next_s;
    logic             limit_next_s;
    logic [TO_W-1:0]  thr_s;
    logic [TO_W-1:0]  cnt_inc_s;

    // Clear request decode: an enable toggle clears both FIFOs.
    always_comb begin
        en_toggle_s = (FCR_D[0] != fifoen_r);
        clr_next_s  = CLR_IDLE;
        rxc_next_s  = 1'b0;
        txc_next_s  = 1'b0;
        if (FCR_WE && (FCR_D[1] || FCR_D[2] || en_toggle_s)) begin
            clr_next_s = CLR_PULSE;
            rxc_next_s = FCR_D[1] | en_toggle_s;
            txc_next_s = FCR_D[2] | en_toggle_s;
        end else begin
            clr_next_s = CLR_IDLE;
            rxc_next_s = 1'b0;
            txc_next_s = 1'b0;
        end
    end

    // RX status next-state: trigger compare and effective full limit.
    always_comb begin
        usage_s      = CMP_W'(RX_USAGE);
        level_s      = CMP_W'(trig_level(fifo64_r, trig_r));
        rda_next_s   = 1'b0;
        limit_next_s = 1'b0;
        // Usage wraps to zero when the FIFO is full, so RX_FULL is ORed in.
        if (fifoen_r) begin
            rda_next_s = (usage_s >= level_s) || RX_FULL;
        end else begin
            rda_next_s = !RX_EMPTY;
        end
        if (fifo64_r) begin
            limit_next_s = RX_FULL;
        end else if (fifoen_r) begin
            limit_next_s = (usage_s >= CMP_W'(8'd16)) || RX_FULL;
        end else begin
            limit_next_s = !RX_EMPTY;
        end
    end

    // Timeout threshold (4 characters x 16 ticks) and saturating increment.
    always_comb begin
        thr_s = TO_W'({FRAME_BITS, 6'b000000});
        if (to_cnt_r == {TO_W{1'b1}}) begin
            cnt_inc_s = to_cnt_r;
        end else begin
            cnt_inc_s = to_cnt_r + TO_W'(1);
        end
    end

    // FCR mode register: FIFO64 only moves under DLAB and is dropped with the enable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fifoen_r <= 1'b0;
            fifo64_r <= 1'b0;
            trig_r   <= 2'b00;
        end else if (FCR_WE) begin
            fifoen_r <= FCR_D[0];
            trig_r   <= FCR_D[7:6];
            if (!FCR_D[0]) begin
                fifo64_r <= 1'b0;
            end else if (DLAB) begin
                fifo64_r <= FCR_D[5];
            end else begin
                fifo64_r <= fifo64_r;
            end
        end else begin
            fifoen_r <= fifoen_r;
            fifo64_r <= fifo64_r;
            trig_r   <= trig_r;
        end
    end

    // Clear FSM: PULSE lasts one cycle; a write during PULSE is evaluated normally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_state_r <= CLR_IDLE;
            rxclear_r   <= 1'b0;
            txclear_r   <= 1'b0;
        end else begin
            case (clr_state_r)
                CLR_IDLE, CLR_PULSE: begin
                    clr_state_r <= clr_next_s;
                    rxclear_r   <= rxc_next_s;
                    txclear_r   <= txc_next_s;
                end
                default: begin
                    clr_state_r <= CLR_IDLE;
                    rxclear_r   <= 1'b0;
                    txclear_r   <= 1'b0;
                end
            endcase
        end
    end

    // Registered RX status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rda_r      <= 1'b0;
            rx_limit_r <= 1'b0;
        end else begin
            rda_r      <= rda_next_s;
            rx_limit_r <= limit_next_s;
        end
    end

    // Character-timeout FSM; CTO is registered alongside the EXPIRED state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_state_r <= TO_IDLE;
            to_cnt_r   <= '0;
            cto_r      <= 1'b0;
        end else if (rxclear_r || RX_EMPTY || !fifoen_r) begin
            to_state_r <= TO_IDLE;
            to_cnt_r   <= '0;
            cto_r      <= 1'b0;
        end else if ((to_state_r != TO_IDLE) && (RX_PUSH || RX_POP)) begin
            to_state_r <= TO_COUNT;
            to_cnt_r   <= '0;
            cto_r      <= 1'b0;
        end else begin
            case (to_state_r)
                TO_IDLE: begin
                    to_state_r <= TO_COUNT;
                    to_cnt_r   <= '0;
                    cto_r      <= 1'b0;
                end
                TO_COUNT: begin
                    if (BAUDCE) begin
                        to_cnt_r <= cnt_inc_s;
                        // Compare uses the threshold live, so FRAME_BITS changes apply here.
                        if (cnt_inc_s >= thr_s) begin
                            to_state_r <= TO_EXPIRED;
                            cto_r      <= 1'b1;
                        end else begin
                            to_state_r <= TO_COUNT;
                            cto_r      <= 1'b0;
                        end
                    end else begin
                        to_cnt_r   <= to_cnt_r;
                        to_state_r <= TO_COUNT;
                        cto_r      <= 1'b0;
                    end
                end
                TO_EXPIRED: begin
                    to_state_r <= TO_EXPIRED;
                    to_cnt_r   <= to_cnt_r;
                    cto_r      <= 1'b1;
                end
                default: begin
                    to_state_r <= TO_IDLE;
                    to_cnt_r   <= '0;
                    cto_r      <= 1'b0;
                end
            endcase
        end
    end

    assign FIFOEN   = fifoen_r;
    assign FIFO64   = fifo64_r;
    assign RXCLEAR  = rxclear_r;
    assign TXCLEAR  = txclear_r;
    assign RX_LIMIT = rx_limit_r;
    assign RDA      = rda_r;
    assign CTO      = cto_r;

endmodule
